// File: rtl/j1g_pkg.sv
// Shared encodings for the j1g stack CPU: instruction classes, ALU opcodes,
// stack-delta codes and fault flag positions.
package j1g_pkg;

    typedef enum logic [1:0] {
        CLS_JUMP    = 2'b00,
        CLS_BRANCH0 = 2'b01,
        CLS_CALL    = 2'b10,
        CLS_ALU     = 2'b11
    } insn_class_e;

    // Low byte of an ALU instruction.
    typedef struct packed {
        logic       r2p;
        logic       n2a;
        logic       t2r;
        logic       t2n;
        logic [1:0] rdelta;
        logic [1:0] ddelta;
    } alu_ctl_t;

    localparam logic [4:0] OP_T     = 5'h00;
    localparam logic [4:0] OP_N     = 5'h01;
    localparam logic [4:0] OP_ADD   = 5'h02;
    localparam logic [4:0] OP_AND   = 5'h03;
    localparam logic [4:0] OP_OR    = 5'h04;
    localparam logic [4:0] OP_XOR   = 5'h05;
    localparam logic [4:0] OP_INV   = 5'h06;
    localparam logic [4:0] OP_EQ    = 5'h07;
    localparam logic [4:0] OP_LT    = 5'h08;
    localparam logic [4:0] OP_SAR   = 5'h09;
    localparam logic [4:0] OP_DEC   = 5'h0A;
    localparam logic [4:0] OP_R     = 5'h0B;
    localparam logic [4:0] OP_MEM   = 5'h0C;
    localparam logic [4:0] OP_SHL   = 5'h0D;
    localparam logic [4:0] OP_DEPTH = 5'h0E;
    localparam logic [4:0] OP_ULT   = 5'h0F;
    localparam logic [4:0] OP_SHR   = 5'h10;
    localparam logic [4:0] OP_FAULT = 5'h11;

    localparam logic [1:0] DELTA_PUSH = 2'b01;
    localparam logic [1:0] DELTA_POP  = 2'b11;

    localparam int FLT_DOVF = 0;
    localparam int FLT_DUNF = 1;
    localparam int FLT_ROVF = 2;
    localparam int FLT_RUNF = 3;

endpackage

// File: rtl/j1g_stack.sv
// Register-array LIFO used for both j1g stacks. Saturates on overflow, reads
// zero on underflow, and flags either condition with a single-cycle pulse.
module j1g_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 15
) (
    input  logic                       clk,
    input  logic                       resetq,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       wr_top,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       ovf,
    output logic                       unf
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             full;
    logic             empty;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    push_idx;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign top_idx  = AW'(count - 1'b1);
    assign push_idx = AW'(count);
    assign top      = empty ? '0 : mem[top_idx];
    assign ovf      = push && full;
    assign unf      = pop && empty;

    // NOTE: sequential state is assigned with non-blocking '<=' so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + 1'b1;
        end else if (pop && !empty) begin
            count <= count - 1'b1;
        end
    end

    // NOTE: the entry array is deliberately not reset; count alone defines
    // which entries are valid, and unreset storage maps onto plain registers/RAM.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[push_idx] <= wdata;
        end else if (wr_top && !empty) begin
            mem[top_idx] <= wdata;
        end
    end

endmodule

// File: rtl/j1g_core.sv
// j1g stack CPU: one instruction per unstalled cycle from a 1-cycle code ROM,
// with a ready/valid data-memory handshake and sticky stack fault flags.
module j1g_core #(
    parameter int WIDTH        = 16,
    parameter int DSTACK_DEPTH = 15,
    parameter int RSTACK_DEPTH = 17,
    parameter int CODE_AW      = 13
) (
    input  logic               clk,
    input  logic               resetq,
    output logic [CODE_AW-1:0] code_addr,
    input  logic [15:0]        insn,
    output logic [WIDTH-1:0]   mem_addr,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic [WIDTH-1:0]   dout,
    input  logic [WIDTH-1:0]   din,
    input  logic               mem_ready,
    output logic [3:0]         fault
);
    import j1g_pkg::*;

    localparam int DCW = $clog2(DSTACK_DEPTH + 1);
    localparam int RCW = $clog2(RSTACK_DEPTH + 1);

    logic [CODE_AW-1:0] pc, pc_plus_1, pc_n, target;
    logic [WIDTH-1:0]   st0, st0_n, st1, rst0, alu, r_wdata;
    logic               reboot;
    logic [DCW-1:0]     dsp;
    logic [RCW-1:0]     rsp_unused;  // return depth is not architecturally visible
    logic               is_lit, is_alu, stall, exec;
    insn_class_e        cls;
    logic [4:0]         alu_op;
    alu_ctl_t           ctl;
    logic               d_push, d_pop, d_wr, r_push, r_pop, r_wr;
    logic               d_ovf, d_unf, r_ovf, r_unf;

    assign is_lit    = insn[15];
    assign cls       = insn_class_e'(insn[14:13]);
    assign is_alu    = !is_lit && (cls == CLS_ALU);
    assign alu_op    = insn[12:8];
    assign ctl       = alu_ctl_t'(insn[7:0]);
    assign target    = CODE_AW'(insn[12:0]);
    assign pc_plus_1 = pc + 1'b1;

    assign mem_rd   = is_alu && (alu_op == OP_MEM) && !reboot;
    assign mem_wr   = is_alu && ctl.n2a && !reboot;
    assign stall    = (mem_rd || mem_wr) && !mem_ready;
    assign exec     = !reboot && !stall;
    assign mem_addr = st0;
    assign dout     = st1;

    // A stalled insn is re-fetched by presenting the current pc again.
    assign code_addr = exec ? pc_n : (reboot ? '0 : pc);

    always_comb begin
        alu = st0;
        case (alu_op)
            OP_N:     alu = st1;
            OP_ADD:   alu = st0 + st1;
            OP_AND:   alu = st0 & st1;
            OP_OR:    alu = st0 | st1;
            OP_XOR:   alu = st0 ^ st1;
            OP_INV:   alu = ~st0;
            OP_EQ:    alu = {WIDTH{st1 == st0}};
            OP_LT:    alu = {WIDTH{$signed(st1) < $signed(st0)}};
            OP_SAR:   alu = {st0[WIDTH-1], st0[WIDTH-1:1]};
            OP_DEC:   alu = st0 - 1'b1;
            OP_R:     alu = rst0;
            OP_MEM:   alu = din;
            OP_SHL:   alu = {st0[WIDTH-2:0], 1'b0};
            OP_DEPTH: alu = WIDTH'(dsp);
            OP_ULT:   alu = {WIDTH{st1 < st0}};
            OP_SHR:   alu = {1'b0, st0[WIDTH-1:1]};
            OP_FAULT: alu = WIDTH'(fault);
            default:  alu = st0;
        endcase
    end

    // NOTE: every signal driven here gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        st0_n   = st0;
        pc_n    = pc_plus_1;
        r_wdata = st0;
        d_push  = 1'b0;
        d_pop   = 1'b0;
        d_wr    = 1'b0;
        r_push  = 1'b0;
        r_pop   = 1'b0;
        r_wr    = 1'b0;
        if (is_lit) begin
            st0_n  = WIDTH'(insn[14:0]);
            d_push = 1'b1;
        end else begin
            case (cls)
                CLS_JUMP: pc_n = target;
                CLS_BRANCH0: begin
                    st0_n = st1;
                    d_pop = 1'b1;
                    if (st0 == '0) pc_n = target;
                end
                CLS_CALL: begin
                    r_push  = 1'b1;
                    r_wdata = WIDTH'({pc_plus_1, 1'b0});
                    pc_n    = target;
                end
                default: begin
                    st0_n  = alu;
                    if (ctl.r2p) pc_n = rst0[CODE_AW:1];
                    d_push = (ctl.ddelta == DELTA_PUSH);
                    d_pop  = (ctl.ddelta == DELTA_POP);
                    d_wr   = ctl.t2n && !d_push && !d_pop;
                    r_push = (ctl.rdelta == DELTA_PUSH);
                    r_pop  = (ctl.rdelta == DELTA_POP);
                    // T2R without a push overwrites the R top, mirroring T2N.
                    r_wr   = ctl.t2r && !r_push && !r_pop;
                end
            endcase
        end
        if (!exec) begin
            d_push = 1'b0;
            d_pop  = 1'b0;
            d_wr   = 1'b0;
            r_push = 1'b0;
            r_pop  = 1'b0;
            r_wr   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            pc     <= '0;
            st0    <= '0;
            reboot <= 1'b1;
            fault  <= '0;
        end else begin
            reboot <= 1'b0;
            if (exec) begin
                pc  <= pc_n;
                st0 <= st0_n;
            end
            fault[FLT_DOVF] <= fault[FLT_DOVF] | d_ovf;
            fault[FLT_DUNF] <= fault[FLT_DUNF] | d_unf;
            fault[FLT_ROVF] <= fault[FLT_ROVF] | r_ovf;
            fault[FLT_RUNF] <= fault[FLT_RUNF] | r_unf;
        end
    end

    j1g_stack #(.WIDTH(WIDTH), .DEPTH(DSTACK_DEPTH)) u_dstack (
        .clk    (clk),
        .resetq (resetq),
        .push   (d_push),
        .pop    (d_pop),
        .wr_top (d_wr),
        .wdata  (st0),
        .top    (st1),
        .count  (dsp),
        .ovf    (d_ovf),
        .unf    (d_unf)
    );

    j1g_stack #(.WIDTH(WIDTH), .DEPTH(RSTACK_DEPTH)) u_rstack (
        .clk    (clk),
        .resetq (resetq),
        .push   (r_push),
        .pop    (r_pop),
        .wr_top (r_wr),
        .wdata  (r_wdata),
        .top    (rst0),
        .count  (rsp_unused),
        .ovf    (r_ovf),
        .unf    (r_unf)
    );

endmodule

// File: tb/tb_j1g_core.sv
// Directed bench for j1g_core: an ALU vector table plus hand-built programs
// for reboot, control flow, wait states, stack faults and async reset.
module tb_j1g_core;
    import j1g_pkg::*;

    logic        clk;
    logic        resetq;
    logic [15:0] insn, insn32;
    logic [15:0] din;
    logic        mem_ready;

    logic [12:0] code_addr, code_addr32;
    logic [15:0] mem_addr, dout;
    logic        mem_rd, mem_wr, mem_rd32, mem_wr32;
    logic [3:0]  fault, fault32;
    logic [31:0] mem_addr32, dout32;

    logic [15:0] rom [8192];

    int n_tests = 0;
    int n_fail  = 0;

    j1g_core dut (
        .clk       (clk),
        .resetq    (resetq),
        .code_addr (code_addr),
        .insn      (insn),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .dout      (dout),
        .din       (din),
        .mem_ready (mem_ready),
        .fault     (fault)
    );

    j1g_core #(.WIDTH(32)) dut32 (
        .clk       (clk),
        .resetq    (resetq),
        .code_addr (code_addr32),
        .insn      (insn32),
        .mem_addr  (mem_addr32),
        .mem_rd    (mem_rd32),
        .mem_wr    (mem_wr32),
        .dout      (dout32),
        .din       ({16'h0000, din}),
        .mem_ready (mem_ready),
        .fault     (fault32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous code ROM: data for an address appears one cycle later.
    always @(posedge clk) begin
        insn   <= rom[code_addr];
        insn32 <= rom[code_addr32];
    end

    typedef struct packed {
        logic [15:0] n;
        logic [15:0] t;
        logic [15:0] pre;
        logic [4:0]  op;
        logic [15:0] exp;
    } vec_t;

    localparam logic [15:0] PRE_NONE = 16'h6000;
    localparam logic [15:0] PRE_INV  = 16'h6600;

    vec_t vecs [21];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] lit(input logic [15:0] v);
        return 16'h8000 | v;
    endfunction

    function automatic logic [15:0] alu_insn(input logic [4:0] op);
        return {3'b011, op, 8'h00};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 8192; i++) rom[i] = 16'h0000;
    endtask

    // Leaves the bench at the falling edge where reset is released (reboot cycle).
    task automatic do_reset();
        resetq    = 1'b0;
        mem_ready = 1'b1;
        din       = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetq = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        resetq    = 1'b0;
        insn      = 16'h0000;
        insn32    = 16'h0000;
        din       = 16'h0000;
        mem_ready = 1'b1;

        vecs[0]  = '{16'h0012, 16'h0055, PRE_NONE, OP_T,     16'h0055};
        vecs[1]  = '{16'h1234, 16'h0005, PRE_NONE, OP_N,     16'h1234};
        vecs[2]  = '{16'h0001, 16'h0000, PRE_INV,  OP_ADD,   16'h0000};
        vecs[3]  = '{16'h0F0F, 16'h00FF, PRE_NONE, OP_AND,   16'h000F};
        vecs[4]  = '{16'h0F0F, 16'h00FF, PRE_NONE, OP_OR,    16'h0FFF};
        vecs[5]  = '{16'h0F0F, 16'h00FF, PRE_NONE, OP_XOR,   16'h0FF0};
        vecs[6]  = '{16'h0003, 16'h0000, PRE_NONE, OP_INV,   16'hFFFF};
        vecs[7]  = '{16'h0009, 16'h0009, PRE_NONE, OP_EQ,    16'hFFFF};
        vecs[8]  = '{16'h0009, 16'h0008, PRE_NONE, OP_EQ,    16'h0000};
        vecs[9]  = '{16'h0005, 16'h0000, PRE_INV,  OP_LT,    16'h0000};
        vecs[10] = '{16'h0005, 16'h0000, PRE_INV,  OP_ULT,   16'hFFFF};
        vecs[11] = '{16'h0002, 16'h0003, PRE_NONE, OP_LT,    16'hFFFF};
        vecs[12] = '{16'h0000, 16'h0100, PRE_INV,  OP_SAR,   16'hFF7F};
        vecs[13] = '{16'h0000, 16'h0100, PRE_INV,  OP_SHR,   16'h7F7F};
        vecs[14] = '{16'h0000, 16'h0000, PRE_NONE, OP_DEC,   16'hFFFF};
        vecs[15] = '{16'h0000, 16'h4001, PRE_NONE, OP_SHL,   16'h8002};
        vecs[16] = '{16'h0000, 16'h0066, PRE_NONE, OP_R,     16'h0000};
        vecs[17] = '{16'h0011, 16'h0022, PRE_NONE, OP_DEPTH, 16'h0002};
        vecs[18] = '{16'h0011, 16'h0022, PRE_NONE, OP_FAULT, 16'h0000};
        vecs[19] = '{16'h0011, 16'h0077, PRE_NONE, 5'h13,    16'h0077};
        vecs[20] = '{16'h7000, 16'h0100, PRE_NONE, OP_ULT,   16'h0000};

        // Reset and reboot: a memory insn sits on the bus but must not issue.
        clear_rom();
        rom[0] = 16'h6C40;
        rom[1] = 16'h0001;
        resetq = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst code_addr", 32'(code_addr), 32'h0);
        check("rst mem_rd", 32'(mem_rd), 32'h0);
        check("rst mem_wr", 32'(mem_wr), 32'h0);
        check("rst fault", 32'(fault), 32'h0);
        resetq = 1'b1;
        #1;
        check("reboot code_addr", 32'(code_addr), 32'h0);
        check("reboot mem_rd", 32'(mem_rd), 32'h0);
        check("reboot mem_wr", 32'(mem_wr), 32'h0);
        step(1);
        check("first insn mem_rd", 32'(mem_rd), 32'h1);
        check("first insn mem_wr", 32'(mem_wr), 32'h1);
        check("first insn code_addr", 32'(code_addr), 32'h1);

        // ALU table: lit n, lit t, optional ~T, op, then spin.
        for (int i = 0; i < 21; i++) begin
            clear_rom();
            rom[0] = lit(vecs[i].n);
            rom[1] = lit(vecs[i].t);
            rom[2] = vecs[i].pre;
            rom[3] = alu_insn(vecs[i].op);
            rom[4] = 16'h0004;
            do_reset();
            step(7);
            check($sformatf("alu[%0d] T", i), 32'(mem_addr), 32'(vecs[i].exp));
            check($sformatf("alu[%0d] N", i), 32'(dout), 32'(vecs[i].n));
        end

        // Literal/ALU sequence and the 32-bit instance shift.
        clear_rom();
        rom[0] = 16'h8005;
        rom[1] = 16'h8007;
        rom[2] = 16'h6203;
        rom[3] = 16'h6E00;
        rom[4] = 16'hFFFF;
        rom[5] = 16'h6D00;
        rom[6] = 16'h0006;
        do_reset();
        step(4);
        check("add T", 32'(mem_addr), 32'd12);
        check("add N", 32'(dout), 32'h0);
        step(1);
        check("depth", 32'(mem_addr), 32'd1);
        step(2);
        check("shl w16", 32'(mem_addr), 32'h0000FFFE);
        check("shl w32", mem_addr32, 32'h0000FFFE);

        // Call/return and branch0.
        clear_rom();
        rom[16'h000] = 16'h0020;
        rom[16'h020] = 16'h4100;
        rom[16'h100] = 16'h6B01;
        rom[16'h101] = 16'h608C;
        rom[16'h021] = 16'h8000;
        rom[16'h022] = 16'h2030;
        rom[16'h030] = 16'h8003;
        rom[16'h031] = 16'h2040;
        rom[16'h032] = 16'h0032;
        rom[16'h040] = 16'h0040;
        do_reset();
        step(1);
        check("jump code_addr", 32'(code_addr), 32'h20);
        step(1);
        check("call code_addr", 32'(code_addr), 32'h100);
        step(2);
        check("R top", 32'(mem_addr), 32'h42);
        check("return code_addr", 32'(code_addr), 32'h21);
        step(1);
        check("return fault", 32'(fault), 32'h0);
        step(1);
        check("branch0 taken", 32'(code_addr), 32'h30);
        step(2);
        check("branch0 not taken", 32'(code_addr), 32'h32);
        step(1);
        check("branch pop T", 32'(mem_addr), 32'h42);
        check("branch fault", 32'(fault), 32'h0);

        // Wait states on a read, then a zero-wait write.
        clear_rom();
        rom[0] = 16'h8022;
        rom[1] = 16'h8050;
        rom[2] = 16'h6C00;
        rom[3] = 16'h6040;
        rom[4] = 16'h0004;
        do_reset();
        mem_ready = 1'b0;
        din       = 16'hBEEF;
        step(3);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("stall%0d mem_rd", c), 32'(mem_rd), 32'h1);
            check($sformatf("stall%0d code_addr", c), 32'(code_addr), 32'h2);
            check($sformatf("stall%0d T", c), 32'(mem_addr), 32'h50);
            step(1);
        end
        mem_ready = 1'b1;
        #1;
        check("stall3 mem_rd", 32'(mem_rd), 32'h1);
        step(1);
        check("read data T", 32'(mem_addr), 32'hBEEF);
        check("read done mem_rd", 32'(mem_rd), 32'h0);
        check("write mem_wr", 32'(mem_wr), 32'h1);
        check("write dout", 32'(dout), 32'h22);
        step(1);
        check("write single cycle", 32'(mem_wr), 32'h0);

        // Data stack overflow with 16 pushes into 15 entries.
        clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = lit(16'(i + 1));
        rom[16] = 16'h6E00;
        rom[17] = 16'h0011;
        do_reset();
        step(16);
        check("15 pushes fault", 32'(fault), 32'h0);
        step(1);
        check("16th push fault", 32'(fault), 32'h1);
        step(1);
        check("overflow depth", 32'(mem_addr), 32'd15);
        check("overflow N kept", 32'(dout), 32'd14);

        // Return stack underflow after reset.
        clear_rom();
        rom[0] = 16'h8007;
        rom[1] = 16'h6B0C;
        rom[2] = 16'h7100;
        rom[3] = 16'h0003;
        do_reset();
        check("fault cleared", 32'(fault), 32'h0);
        step(3);
        check("R underflow value", 32'(mem_addr), 32'h0);
        check("R underflow fault", 32'(fault), 32'h8);
        step(1);
        check("fault op", 32'(mem_addr), 32'h8);

        // Asynchronous reset in the middle of a stall.
        clear_rom();
        rom[0] = 16'h6003;
        rom[1] = 16'h8033;
        rom[2] = 16'h6C00;
        rom[3] = 16'h0003;
        do_reset();
        mem_ready = 1'b0;
        step(4);
        check("pre-reset mem_rd", 32'(mem_rd), 32'h1);
        check("pre-reset fault", 32'(fault), 32'h2);
        check("pre-reset T", 32'(mem_addr), 32'h33);
        #2 resetq = 1'b0;
        #1;
        check("async mem_rd", 32'(mem_rd), 32'h0);
        check("async code_addr", 32'(code_addr), 32'h0);
        check("async fault", 32'(fault), 32'h0);
        check("async T", 32'(mem_addr), 32'h0);
        mem_ready = 1'b1;
        @(negedge clk);
        resetq = 1'b1;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
